// File: rtl/parking_pkg.sv
// Shared types and constants for the parking keypad checker and the gate FSM.
package parking_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] KEY_MAX = 4'd9;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        CHECK,
        GRANT,
        DENY,
        LOCKOUT
    } state_e;

endpackage

// File: rtl/parking_timer.sv
// Saturating up-counter with clear, load and a terminal-count flag.
module parking_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    input  logic [W-1:0] term_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Counting stops at the terminal value, so the counter never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q < term_i)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q >= term_i);

endmodule

// File: rtl/parking_pass_checker.sv
// Keypad code checker: collects a digit code per car and pulses pass_ok or pass_fail.
module parking_pass_checker
    import parking_pkg::*;
#(
    parameter int                        DIGITS      = 4,
    parameter logic [DIGITS*DIGIT_W-1:0] CODE        = 16'h1234,
    parameter int                        MAX_TRIES   = 3,
    parameter int                        TIMEOUT_CYC = 1000,
    parameter int                        LOCK_CYC    = 5000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        key_valid,
    input  logic [DIGIT_W-1:0]          key_digit,
    input  logic                        key_clear,
    input  logic                        code_load,
    input  logic [DIGITS*DIGIT_W-1:0]   new_code,
    output logic                        pass_ok,
    output logic                        pass_fail,
    output logic                        locked,
    output logic                        busy,
    output logic [1:0]                  tries_left
);

    localparam int CODE_W = DIGITS * DIGIT_W;
    localparam int TMAX   = (TIMEOUT_CYC > LOCK_CYC) ? TIMEOUT_CYC : LOCK_CYC;
    localparam int CNT_W  = $clog2(TMAX) + 1;
    localparam int DCNT_W = $clog2(DIGITS + 1);
    localparam logic [1:0]        TRIES_FULL = 2'(MAX_TRIES);
    localparam logic [DCNT_W-1:0] LAST_IDX   = DCNT_W'(DIGITS - 1);
    // Terminal counts are one less than the cycle budget because the timers start at zero.
    localparam logic [CNT_W-1:0]  TMO_TERM   = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0]  LOCK_TERM  = CNT_W'(LOCK_CYC - 1);

    state_e              state_q, state_d;
    logic [CODE_W-1:0]   buf_q, buf_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
    logic [1:0]          tries_q, tries_d;
    logic                pass_ok_q, pass_ok_d;
    logic                pass_fail_q, pass_fail_d;
    logic                tmo_clr, tmo_tc;
    logic                lock_clr, lock_tc;
    logic                key_legal;

    assign key_legal = key_valid && (key_digit <= KEY_MAX);
    assign lock_clr  = (state_q != LOCKOUT);

    parking_timer #(.W(CNT_W)) u_tmo_timer (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (tmo_clr),
        .load_i     (1'b0),
        .load_val_i ('0),
        .en_i       (state_q == ENTRY),
        .term_i     (TMO_TERM),
        .tc_o       (tmo_tc)
    );

    parking_timer #(.W(CNT_W)) u_lock_timer (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (lock_clr),
        .load_i     (1'b0),
        .load_val_i ('0),
        .en_i       (state_q == LOCKOUT),
        .term_i     (LOCK_TERM),
        .tc_o       (lock_tc)
    );

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        code_d      = code_q;
        dcnt_d      = dcnt_q;
        tries_d     = tries_q;
        tmo_clr     = (state_q != ENTRY);
        pass_ok_d   = (state_q == GRANT);
        pass_fail_d = (state_q == DENY);
        case (state_q)
            IDLE: begin
                if (code_load) begin
                    code_d = new_code;
                end
                if (start) begin
                    state_d = ENTRY;
                    buf_d   = '0;
                    dcnt_d  = '0;
                end
            end
            ENTRY: begin
                if (key_clear) begin
                    buf_d   = '0;
                    dcnt_d  = '0;
                    tmo_clr = 1'b1;
                end else if (key_legal) begin
                    buf_d   = {buf_q[CODE_W-DIGIT_W-1:0], key_digit};
                    dcnt_d  = dcnt_q + DCNT_W'(1);
                    tmo_clr = 1'b1;
                    if (dcnt_q == LAST_IDX) begin
                        state_d = CHECK;
                    end
                end else if (tmo_tc) begin
                    state_d = DENY;
                end
            end
            CHECK: begin
                state_d = (buf_q == code_q) ? GRANT : DENY;
            end
            GRANT: begin
                tries_d = TRIES_FULL;
                state_d = IDLE;
            end
            DENY: begin
                tries_d = tries_q - 2'd1;
                buf_d   = '0;
                dcnt_d  = '0;
                state_d = (tries_q == 2'd1) ? LOCKOUT : ENTRY;
            end
            LOCKOUT: begin
                if (lock_tc) begin
                    tries_d = TRIES_FULL;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            buf_q       <= '0;
            code_q      <= CODE;
            dcnt_q      <= '0;
            tries_q     <= TRIES_FULL;
            pass_ok_q   <= 1'b0;
            pass_fail_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            code_q      <= code_d;
            dcnt_q      <= dcnt_d;
            tries_q     <= tries_d;
            pass_ok_q   <= pass_ok_d;
            pass_fail_q <= pass_fail_d;
        end
    end

    assign pass_ok    = pass_ok_q;
    assign pass_fail  = pass_fail_q;
    assign locked     = (state_q == LOCKOUT);
    assign busy       = (state_q != IDLE);
    assign tries_left = tries_q;

endmodule

// File: tb/tb_parking_pass_checker.sv
// Scoreboard bench for parking_pass_checker: expected grant/deny events are queued per attempt.
module tb_parking_pass_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_digit = 4'd0;
    logic        key_clear = 1'b0;
    logic        code_load = 1'b0;
    logic [15:0] new_code = 16'h0;
    logic        pass_ok, pass_fail, locked, busy;
    logic [1:0]  tries_left;

    typedef struct packed {
        logic       ok;
        logic       fail;
        logic [1:0] tries;
    } evt_t;

    evt_t sb[$];
    evt_t sb_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [1:0] model_tries = 2'd3;

    parking_pass_checker dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .key_valid  (key_valid),
        .key_digit  (key_digit),
        .key_clear  (key_clear),
        .code_load  (code_load),
        .new_code   (new_code),
        .pass_ok    (pass_ok),
        .pass_fail  (pass_fail),
        .locked     (locked),
        .busy       (busy),
        .tries_left (tries_left)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic press(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        tick();
        key_valid = 1'b0;
        key_digit = 4'd0;
    endtask

    task automatic enter(input logic [15:0] code);
        for (int i = 3; i >= 0; i--) press(code[i*4 +: 4]);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic expect_evt(input logic ok);
        if (ok) model_tries = 2'd3;
        else    model_tries = model_tries - 2'd1;
        sb.push_back('{ok: ok, fail: ~ok, tries: model_tries});
    endtask

    // Every grant/deny pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && (pass_ok || pass_fail)) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", 32'({pass_ok, pass_fail, tries_left}), 32'h0);
            end else begin
                sb_e = sb.pop_front();
                chk("sb_event", 32'({pass_ok, pass_fail, tries_left}), 32'(sb_e));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int n;

        // Reset values
        reset = 1'b1;
        idle(3);
        @(negedge clk);
        chk("rst_pass_ok", 32'(pass_ok), 32'd0);
        chk("rst_pass_fail", 32'(pass_fail), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tries", 32'(tries_left), 32'd3);
        reset = 1'b0;
        tick();

        // Correct code, latency of two edges after the last key
        do_start();
        expect_evt(1'b1);
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        @(negedge clk);
        chk("lat_edge1", 32'(pass_ok), 32'd0);
        @(negedge clk);
        chk("lat_edge2", 32'(pass_ok), 32'd0);
        chk("lat_fail_low", 32'(pass_fail), 32'd0);
        @(negedge clk);
        chk("lat_pass_ok", 32'(pass_ok), 32'd1);
        chk("grant_busy", 32'(busy), 32'd0);
        chk("grant_tries", 32'(tries_left), 32'd3);
        idle(2);

        // Three wrong attempts, then lockout
        do_start();
        for (int a = 0; a < 3; a++) begin
            expect_evt(1'b0);
            enter(16'h1235);
            if (a < 2) idle(3);
        end
        repeat (3) @(negedge clk);
        chk("lock_on", 32'(locked), 32'd1);
        chk("lock_tries", 32'(tries_left), 32'd0);
        n = 1;
        while (locked && n < 6000) begin
            start = (n == 3);
            key_valid = (n >= 5 && n <= 8);
            key_digit = (n >= 5 && n <= 8) ? 4'(n - 4) : 4'd0;
            code_load = (n == 10);
            new_code = 16'h0000;
            @(negedge clk);
            if (locked) n++;
        end
        start = 1'b0; key_valid = 1'b0; key_digit = 4'd0; code_load = 1'b0;
        chk("lock_len_ok", 32'(n >= 5000 && n <= 5001), 32'd1);
        chk("unlock_locked", 32'(locked), 32'd0);
        chk("unlock_busy", 32'(busy), 32'd0);
        chk("unlock_tries", 32'(tries_left), 32'd3);
        model_tries = 2'd3;
        tick();

        // key_clear wins over a simultaneous key; stored code survived lockout
        do_start();
        expect_evt(1'b1);
        press(4'd1); press(4'd2);
        key_clear = 1'b1;
        press(4'd9);
        key_clear = 1'b0;
        enter(16'h1234);
        idle(3);

        // Inter-digit timeout
        do_start();
        press(4'd1);
        expect_evt(1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pass_fail && n < 1200);
        chk("tmo_window", 32'(n >= 1000 && n <= 1003), 32'd1);
        chk("tmo_busy", 32'(busy), 32'd1);
        chk("tmo_tries", 32'(tries_left), 32'd2);
        tick();
        expect_evt(1'b1);
        enter(16'h1234);
        idle(3);

        // Illegal digit is dropped
        do_start();
        expect_evt(1'b1);
        press(4'd1); press(4'hA); press(4'd2); press(4'd3); press(4'd4);
        idle(3);

        // Code load in IDLE
        code_load = 1'b1;
        new_code = 16'h9876;
        tick();
        code_load = 1'b0;
        do_start();
        expect_evt(1'b0);
        enter(16'h1234);
        idle(3);
        expect_evt(1'b1);
        enter(16'h9876);
        idle(3);

        // Load and start in the same cycle
        code_load = 1'b1;
        new_code = 16'h4321;
        start = 1'b1;
        tick();
        code_load = 1'b0;
        start = 1'b0;
        chk("load_start_busy", 32'(busy), 32'd1);
        expect_evt(1'b1);
        enter(16'h4321);
        idle(3);

        // Reset mid-entry restores the power-on code
        do_start();
        press(4'd9); press(4'd8);
        reset = 1'b1;
        idle(2);
        @(negedge clk);
        chk("rst2_busy", 32'(busy), 32'd0);
        chk("rst2_locked", 32'(locked), 32'd0);
        chk("rst2_tries", 32'(tries_left), 32'd3);
        chk("rst2_pulses", 32'({pass_ok, pass_fail}), 32'd0);
        reset = 1'b0;
        model_tries = 2'd3;
        do_start();
        expect_evt(1'b0);
        enter(16'h9876);
        idle(3);
        expect_evt(1'b1);
        enter(16'h1234);
        idle(4);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/parking_pass_checker.md
Name: parking_pass_checker

Overview:
- Keypad-side producer of the pass_ok strobe consumed by the parking gate FSM.
- Collects a fixed-length digit code after a car is detected and compares it against a stored code.
- Emits a one-cycle grant (pass_ok) or deny (pass_fail) pulse per attempt.
- Enforces an inter-digit timeout and a lockout after repeated wrong attempts.

Parameters:
- DIGITS, 4, number of digits per code.
- CODE, 16'h1234, reset value of stored code; BCD, first-entered digit in the MSB nibble; width DIGITS*4.
- MAX_TRIES, 3, consecutive wrong attempts before lockout.
- TIMEOUT_CYC, 1000, idle cycles allowed between key presses in ENTRY.
- LOCK_CYC, 5000, lockout duration in cycles.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  car detected; opens an entry session (driven from car_in).
- key_valid  in  1  one-cycle strobe; key_digit is valid.
- key_digit  in  4  BCD digit; values 10..15 are illegal.
- key_clear  in  1  discard the digits entered so far in this attempt.
- code_load  in  1  load new_code into the stored code.
- new_code  in  DIGITS*4  replacement code, BCD.
- pass_ok  out  1  one-cycle grant pulse.
- pass_fail  out  1  one-cycle deny pulse.
- locked  out  1  high during lockout.
- busy  out  1  high in any state other than IDLE.
- tries_left  out  2  remaining attempts; sized for MAX_TRIES ≤ 3.

Behaviour:
- One clock domain. Reset is synchronous and active-high on clk and reset, and overrides everything.
- Reset values: state IDLE, pass_ok 0, pass_fail 0, locked 0, busy 0, tries_left MAX_TRIES, digit buffer 0, digit count 0, timers 0, stored code CODE.
- All outputs are registered or Moore-decoded from state. There is no combinational path from any input to any output.
- IDLE:
  - start -> ENTRY; clear buffer, count and timer.
  - code_load is accepted only in IDLE and stores new_code. It is ignored in every other state.
  - If start and code_load arrive in the same cycle, the load completes and the state still moves to ENTRY.
- ENTRY:
  - A legal key (key_valid=1, digit ≤ 9) shifts in: buffer <= {buffer, key_digit}. Count increments and the timer restarts.
  - An illegal digit is dropped. It is not counted and does not restart the timer.
  - key_clear zeroes buffer and count and restarts the timer. It is not an attempt, and it wins over a simultaneous key_valid.
  - The key that brings count to DIGITS moves the state to CHECK.
  - Timer reaching TIMEOUT_CYC with no legal key -> DENY. This counts as a wrong attempt.
- CHECK: one cycle; buffer == stored code -> GRANT, else DENY.
- GRANT:
  - pass_ok=1 for exactly one cycle; tries_left reloads to MAX_TRIES; -> IDLE.
  - Latency: pass_ok is high in the cycle after the 2nd rising edge following the edge that sampled the final digit.
- DENY:
  - pass_fail=1 for exactly one cycle; tries_left decrements.
  - If the new tries_left is 0 -> LOCKOUT; else -> ENTRY with buffer, count and timer cleared.
- LOCKOUT:
  - locked=1; all key, start and code_load inputs are ignored.
  - After LOCK_CYC cycles -> IDLE with tries_left reloaded to MAX_TRIES.
- start is ignored outside IDLE.
- pass_ok and pass_fail are never high together.
- Reset mid-entry discards the partial code but keeps nothing else. The stored code also returns to CODE.
- The timers saturate and never wrap. Counter width is $clog2 of max(TIMEOUT_CYC, LOCK_CYC) plus 1.

Decomposition:
- Package parking_pkg holds:
  - state enum: IDLE, ENTRY, CHECK, GRANT, DENY, LOCKOUT;
  - DIGIT_W=4;
  - KEY_MAX=9.
- The gate FSM shares this package.
- One sub-module, parking_timer: a loadable up-counter with a clear input and a terminal-count flag. It is instantiated twice, once for the inter-digit timeout and once for lockout.

Test Plan:
- start, then keys 1,2,3,4 on consecutive cycles -> pass_ok=1 for exactly one cycle, 2 edges after key 4; tries_left=3; back to IDLE with busy=0.
- Three attempts of 1,2,3,5 -> three pass_fail pulses and tries_left 2,1,0. After the third, locked=1 for 5000 cycles, and a start or key during lockout has no effect; then IDLE with tries_left=3.
- keys 1,2, key_clear asserted together with key 9, then 1,2,3,4 -> the 9 is discarded; pass_ok pulse; no pass_fail.
- key 1, then 1000 idle cycles -> pass_fail pulse, tries_left=2, state ENTRY; then 1,2,3,4 -> pass_ok.
- keys 1, 0xA, 2, 3, 4 -> 0xA is ignored; pass_ok pulse.
- code_load with 16'h9876 in IDLE, then start, 1,2,3,4 -> pass_fail; then 9,8,7,6 -> pass_ok. Next, reset after keys 9,8 of a new session -> all outputs at reset values; 9,8,7,6 now fails and 1,2,3,4 passes.
